// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial equality checker: FSM encodings and default word width.
// Pure declarations; no latency and no backpressure of its own.
package serial_cmp_pkg;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/serial_eq_checker_if.sv
// Handshake and result bundle of the serial equality checker (optional FIRST_MISMATCH_EN fields).
// Wires only; no latency. in_ready qualifies in_valid for backpressure.
interface serial_eq_checker_if #(
    parameter int WIDTH = serial_cmp_pkg::DEFAULT_WIDTH
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    logic          start;
    logic          abort;
    logic          in_valid;
    logic          a_bit;
    logic          b_bit;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic          equal;
    logic [CW-1:0] match_count;
`ifdef FIRST_MISMATCH_EN
    logic          mismatch_seen;
    logic [IW-1:0] first_mismatch;
`endif

    modport slave (
        input  start, abort, in_valid, a_bit, b_bit,
        output in_ready, busy, done, equal, match_count
`ifdef FIRST_MISMATCH_EN
        , output mismatch_seen, first_mismatch
`endif
    );

    modport master (
        output start, abort, in_valid, a_bit, b_bit,
        input  in_ready, busy, done, equal, match_count
`ifdef FIRST_MISMATCH_EN
        , input mismatch_seen, first_mismatch
`endif
    );
endinterface

// File: rtl/xnor_logic.sv
// Single-bit equality: y_o is high when a_i and b_i agree.
// Combinational, zero latency; no backpressure.
module xnor_logic (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i ^ b_i);
endmodule

// File: rtl/serial_eq_checker.sv
// Compares WIDTH serial bit pairs, reporting equal and match_count (first mismatch with FIRST_MISMATCH_EN).
// done pulses the cycle after the last accepted beat; in_ready is high only in SHIFT, so idle beats are dropped.
module serial_eq_checker
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_eq_checker_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] mc_q, mc_d;
    logic          flag_q, flag_d;
    logic          eq_q, eq_d;
    logic          m;
`ifdef FIRST_MISMATCH_EN
    logic          seen_q, seen_d;
    logic [IW-1:0] fm_q, fm_d;
`endif

    xnor_logic u_xnor (
        .a_i (bus.a_bit),
        .b_i (bus.b_bit),
        .y_o (m)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        flag_d  = flag_q;
        eq_d    = eq_q;
`ifdef FIRST_MISMATCH_EN
        seen_d  = seen_q;
        fm_d    = fm_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // abort outranks a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    mc_d    = '0;
                    flag_d  = 1'b1;
                    eq_d    = 1'b0;
`ifdef FIRST_MISMATCH_EN
                    seen_d  = 1'b0;
                    fm_d    = '0;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    mc_d    = '0;
                    flag_d  = 1'b0;
                    eq_d    = 1'b0;
`ifdef FIRST_MISMATCH_EN
                    seen_d  = 1'b0;
                    fm_d    = '0;
`endif
                end else if (bus.in_valid) begin
                    cnt_d  = cnt_q + CW'(1);
                    mc_d   = mc_q + {{(CW-1){1'b0}}, m};
                    flag_d = flag_q & m;
`ifdef FIRST_MISMATCH_EN
                    if (!m && !seen_q) begin
                        seen_d = 1'b1;
                        fm_d   = cnt_q[IW-1:0];
                    end
`endif
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        eq_d    = flag_q & m;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mc_q    <= '0;
            flag_q  <= 1'b0;
            eq_q    <= 1'b0;
`ifdef FIRST_MISMATCH_EN
            seen_q  <= 1'b0;
            fm_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            flag_q  <= flag_d;
            eq_q    <= eq_d;
`ifdef FIRST_MISMATCH_EN
            seen_q  <= seen_d;
            fm_q    <= fm_d;
`endif
        end
    end

    assign bus.in_ready    = (state_q == SHIFT);
    assign bus.busy        = (state_q == SHIFT);
    assign bus.done        = (state_q == DONE);
    assign bus.equal       = eq_q;
    assign bus.match_count = mc_q;
`ifdef FIRST_MISMATCH_EN
    assign bus.mismatch_seen  = seen_q;
    assign bus.first_mismatch = fm_q;
`endif
endmodule

// File: tb/tb_serial_eq_checker.sv
// Directed bench for serial_eq_checker at WIDTH=4; build with FIRST_MISMATCH_EN to cover the optional outputs.
module tb_serial_eq_checker;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;

    serial_eq_checker_if #(.WIDTH(W)) bus ();

    serial_eq_checker #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic a, input logic b);
        bus.in_valid = 1'b1;
        bus.a_bit    = a;
        bus.b_bit    = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic eq, input int mc);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_equal"}, {31'd0, bus.equal}, {31'd0, eq});
        chk({tag, "_mc"}, 32'(bus.match_count), 32'(mc));
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_bit    = 1'b0;
        bus.b_bit    = 1'b0;
        #12;
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_done",  {31'd0, bus.done}, 32'd0);
        chk("rst_equal", {31'd0, bus.equal}, 32'd0);
        chk("rst_mc",    32'(bus.match_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // all four beats match, back to back
        do_start();
        chk("t1_busy",  {31'd0, bus.busy}, 32'd1);
        chk("t1_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t1_mc0",   32'(bus.match_count), 32'd0);
        beat(1, 1);
        beat(0, 0);
        beat(1, 1);
        chk("t1_nodone", {31'd0, bus.done}, 32'd0);
        chk("t1_eq_shift", {31'd0, bus.equal}, 32'd0);
        beat(0, 0);
        chk_done("t1", 1'b1, 4);
        bus.abort = 1'b1;  // abort in DONE has no effect on results
        tick();
        bus.abort = 1'b0;
        chk("t1_pulse_end", {31'd0, bus.done}, 32'd0);
        chk("t1_hold_eq", {31'd0, bus.equal}, 32'd1);
        chk("t1_hold_mc", 32'(bus.match_count), 32'd4);
        chk("t1_idle_busy", {31'd0, bus.busy}, 32'd0);

        // two mismatches, first at beat 1
        do_start();
        chk("t2_cleared_eq", {31'd0, bus.equal}, 32'd0);
        chk("t2_cleared_mc", 32'(bus.match_count), 32'd0);
        beat(1, 1);
        chk("t2_mc1", 32'(bus.match_count), 32'd1);
        beat(0, 1);
        beat(1, 1);
        beat(1, 0);
        chk_done("t2", 1'b0, 2);
`ifdef FIRST_MISMATCH_EN
        chk("t2_seen", {31'd0, bus.mismatch_seen}, 32'd1);
        chk("t2_first", 32'(bus.first_mismatch), 32'd1);
`endif

        // stalls between beats plus a start pulse mid-word
        do_start();
        for (int i = 0; i < W; i++) begin
            beat(1, 1);
            if (i < W - 1) begin
                for (int j = 0; j < 3; j++) begin
                    if (i == 1 && j == 1) bus.start = 1'b1;
                    tick();
                    bus.start = 1'b0;
                    chk("t3_stall_nodone", {31'd0, bus.done}, 32'd0);
                    chk("t3_stall_mc", 32'(bus.match_count), 32'(i + 1));
                end
            end
        end
        chk_done("t3", 1'b1, 4);
        tick();

        // abort with start mid-word, then a normal run
        do_start();
        beat(1, 0);
        beat(1, 1);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("t4_busy", {31'd0, bus.busy}, 32'd0);
        chk("t4_done", {31'd0, bus.done}, 32'd0);
        chk("t4_mc", 32'(bus.match_count), 32'd0);
        chk("t4_eq", {31'd0, bus.equal}, 32'd0);
`ifdef FIRST_MISMATCH_EN
        chk("t4_seen", {31'd0, bus.mismatch_seen}, 32'd0);
`endif
        tick();
        chk("t4_still_nodone", {31'd0, bus.done}, 32'd0);
        do_start();
        beat(0, 0);
        beat(1, 1);
        beat(1, 1);
        beat(0, 1);
        chk_done("t4b", 1'b0, 3);
`ifdef FIRST_MISMATCH_EN
        chk("t4b_first", 32'(bus.first_mismatch), 32'd3);
`endif
        tick();

        // asynchronous reset mid-word
        do_start();
        beat(1, 1);
        beat(1, 1);
        beat(1, 1);
        chk("t5_pre_mc", 32'(bus.match_count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("t5_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t5_rst_mc",    32'(bus.match_count), 32'd0);
        #2;
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.a_bit    = 1'b1;
        bus.b_bit    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("t5_no_accept", 32'(bus.match_count), 32'd0);
            chk("t5_no_done", {31'd0, bus.done}, 32'd0);
        end
        bus.in_valid = 1'b0;
        do_start();
        beat(1, 1);
        beat(0, 0);
        beat(0, 0);
        beat(1, 1);
        chk_done("t5b", 1'b1, 4);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_eq_checker.md
SERIAL_EQ_CHECKER -- requirements
Module: serial_eq_checker

Interface
REQ-001 Parameter WIDTH, default 8: number of bit pairs compared per word (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a new comparison.
REQ-005 abort  input  1  cancel the comparison in progress.
REQ-006 in_valid  input  1  a_bit/b_bit pair is valid this cycle.
REQ-007 a_bit  input  1  operand A serial bit, beat 0 first.
REQ-008 b_bit  input  1  operand B serial bit, beat 0 first.
REQ-009 in_ready  output  1  block accepts a bit pair this cycle.
REQ-010 busy  output  1  comparison in progress.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 equal  output  1  all WIDTH pairs matched.
REQ-013 match_count  output  CW=$clog2(WIDTH+1)  number of matching pairs.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL clear bit counter, match_count and equal, and SHALL enter SHIFT the next cycle.
REQ-016 In SHIFT, start SHALL be ignored.
REQ-017 In SHIFT, in_ready=1 and busy=1; in IDLE and DONE, both SHALL be 0.
REQ-018 A beat SHALL be accepted only when in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored.
REQ-019 Per accepted beat: m = a_bit XNOR b_bit; match_count += m; running all-equal flag &= m; bit counter += 1.
REQ-020 On the beat that makes bit counter = WIDTH, the FSM SHALL go to DONE; done=1 in the following cycle, exactly one cycle, then IDLE.
REQ-021 equal SHALL be driven only in the DONE cycle and afterwards, equal to the running flag; it is 0 while in SHIFT.
REQ-022 match_count and equal SHALL hold their values from DONE until the next accepted start or reset.
REQ-023 Cycles with in_valid=0 in SHIFT SHALL stall without state change; there is no timeout.
REQ-024 abort=1 in SHIFT SHALL go to IDLE next cycle, with no done pulse and match_count=0, equal=0.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 When abort and start are both asserted, abort SHALL win.
REQ-027 match_count SHALL never exceed WIDTH, and the bit counter SHALL not wrap.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE; in_ready, busy, done, equal and match_count = 0; bit counter = 0.
REQ-029 Reset mid-SHIFT SHALL discard the partial word; after release, a new start is required.

Configuration
REQ-030 With FIRST_MISMATCH_EN defined, the block SHALL add outputs mismatch_seen (1) and first_mismatch (IW=$clog2(WIDTH)).
REQ-031 first_mismatch SHALL capture the beat index of the first pair with m=0; mismatch_seen is set with it; both are cleared by start, abort and reset, and held like match_count.
REQ-032 Without FIRST_MISMATCH_EN, those ports and registers SHALL be absent, with behaviour otherwise identical.

Structure
REQ-033 Shared package serial_cmp_pkg SHALL hold the FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH.
REQ-034 The per-beat XNOR SHALL be an instance of the existing xnor_logic sub-module; FSM and counters are local.

Verification (WIDTH=4)
REQ-035 Start, then beats (a,b)=(1,1),(0,0),(1,1),(0,0) back-to-back -> done pulse 1 cycle after beat 3, equal=1, match_count=4, busy low after done.
REQ-036 Start, then beats (1,1),(0,1),(1,1),(1,0) -> equal=0, match_count=2; with FIRST_MISMATCH_EN, first_mismatch=1 and mismatch_seen=1.
REQ-037 Start, then 4 matching beats with in_valid low 3 cycles between beats -> no early done, match_count=4; start pulsed mid-word -> ignored.
REQ-038 Start, 2 beats, then abort together with start -> IDLE, no done, match_count=0; subsequent start runs normally.
REQ-039 rst_n low after 3 beats -> outputs 0 asynchronously; after release, in_valid without start -> in_ready=0, nothing accepted.
